io_timer: RTL and testbench

- Memory-mapped 8-bit compare timer that responds to CPU IO-bus accesses in the 0x10xx IO window and acts as an interrupt source to the CPU.
- It is the responder side of the CPU data/IO bus: it decodes address and read/write enables, returns registered read data, and raises an interrupt line that the CPU acknowledges through a clear strobe.
- It drives a toggle output on each compare match for waveform/PWM-style use.

---
 rtl/io_timer_pkg.sv | 28 ++
 rtl/io_timer_prescaler.sv | 43 ++++
 rtl/io_timer.sv | 124 ++++++++++++
 tb/tb_io_timer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/io_timer_pkg.sv
// io_timer_pkg: shared constants for the IO-mapped compare timer.
//   - register offsets inside the 4-byte window
//   - CTRL / STATUS bit positions
//   - reset value of the compare register
package io_timer_pkg;

  // Register offsets (address[1:0])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_CMP    = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN           = 0;
  localparam int CTRL_CLR_ON_MATCH = 1;
  localparam int CTRL_IE           = 2;
  localparam int CTRL_PSEL_LSB     = 3;
  localparam int CTRL_PSEL_MSB     = 5;
  localparam int CTRL_W            = 6;  // bits 7:6 are not stored and read 0

  // STATUS bit indices
  localparam int STAT_FLAG = 0;
  localparam int STAT_IRQ  = 1;

  // Reset value of CMP
  localparam logic [7:0] CMP_RST = 8'hFF;

endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer_prescaler: 7-bit free-running prescaler producing a 1-cycle tick
// every 2^psel enabled cycles.
//   clk    in  system clock
//   reset  in  synchronous active-low reset
//   en     in  count enable; prescaler held at 0 while low
//   clr    in  restart the prescale period (CPU write to COUNT or CTRL)
//   psel   in  divide select, ratio = 2^psel
//   tick   out advance COUNT this cycle
module io_timer_prescaler
  import io_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] psel,
  output logic       tick
);

  logic [6:0] pre_q;
  logic [6:0] pre_d;
  logic [6:0] mask;

  // mask = (1 << psel) - 1, built without a wider intermediate
  always_comb begin
    mask = ~(7'h7F << psel);
    tick = en & ((pre_q & mask) == mask);
    if (!en || clr) begin
      pre_d = 7'd0;
    end else begin
      pre_d = pre_q + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q <= 7'd0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/io_timer.sv
// io_timer: 8-bit compare timer on the CPU IO bus (4 registers at BASE_ADDR).
//   clk            in  system clock
//   reset          in  synchronous active-low reset
//   address        in  CPU IO address (window decode on [15:2], offset [1:0])
//   data_in        in  CPU write data
//   data_out       out registered read data, 0 when not selected
//   write_en       in  CPU write strobe
//   read_en        in  CPU read strobe
//   interrupt      out level IRQ = FLAG & IE
//   interrupt_clr  in  CPU acknowledge, clears FLAG
//   match_out      out toggles on every compare match
// Bus handshake: a strobe is accepted at every clk edge where it is high and
// the address is selected; there is no back-pressure. Read data is valid on
// data_out exactly one cycle after read_en and reflects pre-edge state.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h1010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        write_en,
  input  logic        read_en,
  output logic        interrupt,
  input  logic        interrupt_clr,
  output logic        match_out
);

  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic              flag_q,  flag_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        cmp_q,   cmp_d;
  logic              match_q, match_d;
  logic [7:0]        rdata_q, rdata_d;

  logic       sel;
  logic [1:0] off;
  logic       wr_ctrl, wr_status, wr_count, wr_cmp;
  logic       tick;
  logic       tick_eff;
  logic [7:0] rdata;

  assign sel       = (address[15:2] == BASE_ADDR[15:2]);
  assign off       = address[1:0];
  assign wr_ctrl   = write_en & sel & (off == OFF_CTRL);
  assign wr_status = write_en & sel & (off == OFF_STATUS);
  assign wr_count  = write_en & sel & (off == OFF_COUNT);
  assign wr_cmp    = write_en & sel & (off == OFF_CMP);

  io_timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (wr_ctrl | wr_count),
    .psel  (ctrl_q[CTRL_PSEL_MSB:CTRL_PSEL_LSB]),
    .tick  (tick)
  );

  // A CPU write to COUNT overrides the tick entirely: no increment, no match.
  assign tick_eff = tick & ~wr_count;

  always_comb begin
    case (off)
      OFF_CTRL:   rdata = {{(8-CTRL_W){1'b0}}, ctrl_q};
      OFF_STATUS: rdata = {6'd0, interrupt, flag_q};
      OFF_COUNT:  rdata = count_q;
      default:    rdata = cmp_q;
    endcase
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    flag_d  = flag_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    rdata_d = (read_en & sel) ? rdata : 8'h00;

    if (wr_ctrl) ctrl_d = data_in[CTRL_W-1:0];
    if (wr_cmp)  cmp_d  = data_in;

    // Clears first so a same-cycle match set below wins.
    if (interrupt_clr || (wr_status && data_in[STAT_FLAG])) flag_d = 1'b0;

    if (tick_eff) begin
      // Compare uses the pre-edge CMP, so a same-cycle CMP write lands next tick.
      if (count_q == cmp_q) begin
        count_d = ctrl_q[CTRL_CLR_ON_MATCH] ? 8'h00 : count_q + 8'd1;
        flag_d  = 1'b1;
        match_d = ~match_q;
      end else begin
        count_d = count_q + 8'd1;
      end
    end

    if (wr_count) count_d = data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= '0;
      flag_q  <= 1'b0;
      count_q <= 8'h00;
      cmp_q   <= CMP_RST;
      match_q <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_out  = rdata_q;
  assign match_out = match_q;
  assign interrupt = flag_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed bench for io_timer. Reads push their expected data
// into exp_q; a monitor pops and compares one cycle after each read strobe.
module tb_io_timer;

  localparam logic [15:0] BASE = 16'h1010;
  localparam logic [15:0] A_CTRL   = BASE + 16'd0;
  localparam logic [15:0] A_STATUS = BASE + 16'd1;
  localparam logic [15:0] A_COUNT  = BASE + 16'd2;
  localparam logic [15:0] A_CMP    = BASE + 16'd3;
  localparam logic [15:0] A_OUT    = BASE + 16'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic        interrupt;
  logic        interrupt_clr = 1'b0;
  logic        match_out;

  logic [7:0] exp_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic       rd_seen = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  io_timer #(.BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .write_en      (write_en),
    .read_en       (read_en),
    .interrupt     (interrupt),
    .interrupt_clr (interrupt_clr),
    .match_out     (match_out)
  );

  // scoreboard monitor
  always @(posedge clk) rd_seen <= read_en;

  always @(negedge clk) begin
    logic [7:0] e;
    if (rd_seen) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_data: data_out=%02h with no expected entry", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out === e) pass_cnt++;
        else $display("FAIL rd_data: got %02h expected %02h", data_out, e);
      end
    end
  end

  // driver tasks: inputs change 1 time unit after a posedge
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a; data_in = d; write_en = 1'b1;
    cyc();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    address = a; read_en = 1'b1;
    exp_q.push_back(e);
    cyc();
    read_en = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] e);
    total_cnt++;
    if (act === e) pass_cnt++;
    else $display("FAIL %s: got %02h expected %02h", name, act, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    cyc(3);
    chk("rst_irq", {7'd0, interrupt}, 8'h00);
    chk("rst_match", {7'd0, match_out}, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    reset = 1'b1;
    rd(A_CTRL, 8'h00);
    rd(A_STATUS, 8'h00);
    rd(A_COUNT, 8'h00);
    rd(A_CMP, 8'hFF);
    rd(A_OUT, 8'h00);

    // CMP=3, EN|CLR|IE, PSEL=0: COUNT 0,1,2,3 then clears to 0
    wr(A_CMP, 8'h03);
    wr(A_CTRL, 8'h07);
    rd(A_COUNT, 8'h00);
    rd(A_COUNT, 8'h01);
    rd(A_COUNT, 8'h02);
    chk("t2_irq_pre", {7'd0, interrupt}, 8'h00);
    rd(A_COUNT, 8'h03);
    chk("t2_irq_post", {7'd0, interrupt}, 8'h01);
    chk("t2_match", {7'd0, match_out}, 8'h01);
    rd(A_COUNT, 8'h00);
    wr(A_CTRL, 8'h04);          // stop; last enabled tick makes COUNT 2
    rd(A_COUNT, 8'h02);
    rd(A_STATUS, 8'h03);
    chk("t2_match_hold", {7'd0, match_out}, 8'h01);

    // interrupt_clr acknowledge
    interrupt_clr = 1'b1;
    cyc();
    interrupt_clr = 1'b0;
    chk("ack_irq", {7'd0, interrupt}, 8'h00);

    // match coincident with interrupt_clr: set wins
    wr(A_COUNT, 8'h05);
    wr(A_CMP, 8'h05);
    wr(A_CTRL, 8'h05);          // EN|IE, no clear-on-match, PSEL=0
    interrupt_clr = 1'b1;
    cyc();
    interrupt_clr = 1'b0;
    chk("setwin_irq", {7'd0, interrupt}, 8'h01);
    chk("setwin_match", {7'd0, match_out}, 8'h00);
    wr(A_CTRL, 8'h04);          // stop at COUNT 7
    rd(A_COUNT, 8'h07);
    wr(A_STATUS, 8'hFE);        // bit0 clear: no effect
    chk("stat_fe_irq", {7'd0, interrupt}, 8'h01);
    wr(A_STATUS, 8'h01);
    chk("stat_01_irq", {7'd0, interrupt}, 8'h00);

    // PSEL=2, CMP=FF, wrap FF->00 with FLAG
    wr(A_COUNT, 8'hFD);
    wr(A_CMP, 8'hFF);
    wr(A_CTRL, 8'h15);          // EN|IE|PSEL=2 (edge F0)
    cyc(3);
    rd(A_COUNT, 8'hFD);         // F4, tick lands here
    cyc(2);
    rd(A_COUNT, 8'hFE);         // F7
    rd(A_COUNT, 8'hFE);         // F8, tick lands here
    chk("ps_irq_a", {7'd0, interrupt}, 8'h00);
    cyc(3);
    chk("ps_irq_b", {7'd0, interrupt}, 8'h00);
    rd(A_COUNT, 8'hFF);         // F12, match/wrap
    chk("ps_irq_c", {7'd0, interrupt}, 8'h01);
    chk("ps_match", {7'd0, match_out}, 8'h01);
    rd(A_COUNT, 8'h00);         // F13

    // COUNT write on a tick edge (F16) wins; next tick a full period later
    cyc(2);
    wr(A_COUNT, 8'h10);         // F16
    rd(A_COUNT, 8'h10);         // F17
    cyc(2);
    rd(A_COUNT, 8'h10);         // F20, tick lands here
    rd(A_COUNT, 8'h11);         // F21

    // reset mid-count with FLAG=1, match_out=1 and a read in flight
    address = A_CMP; read_en = 1'b1; reset = 1'b0;
    exp_q.push_back(8'h00);
    cyc();
    read_en = 1'b0; reset = 1'b1;
    chk("rst2_irq", {7'd0, interrupt}, 8'h00);
    chk("rst2_match", {7'd0, match_out}, 8'h00);
    cyc(5);
    rd(A_CTRL, 8'h00);
    rd(A_STATUS, 8'h00);
    rd(A_COUNT, 8'h00);
    rd(A_CMP, 8'hFF);

    // read+write same cycle returns pre-write value
    address = A_CMP; data_in = 8'h42; write_en = 1'b1; read_en = 1'b1;
    exp_q.push_back(8'hFF);
    cyc();
    write_en = 1'b0; read_en = 1'b0;
    rd(A_CMP, 8'h42);
    wr(A_OUT, 8'h55);           // unselected: no effect
    rd(A_CMP, 8'h42);
    wr(A_CTRL, 8'hC0);          // bits 7:6 not stored
    rd(A_CTRL, 8'h00);

    cyc(2);
    chk("exp_q_drained", 8'(exp_q.size()), 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
